// File: rtl/scratch_mem_arbiter_pkg.sv
// Shared encodings and widths for the scratch-memory arbiter and its round-robin picker.
package scratch_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 32;
    localparam int WORD_W  = 16;
    localparam int ID_W    = 3;
    localparam int TIMER_W = 12;

endpackage

// File: rtl/scratch_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module scratch_mem_arbiter_rr_pick
    import scratch_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pickId,
    output logic               found
);

    logic [2*NUM_REQ-1:0] rotated;
    logic [ID_W:0]        sum;

    always_comb begin
        // Doubling the vector turns the wrap-around search into a plain shift.
        rotated = {req, req} >> pointer;
        found   = 1'b0;
        sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                sum   = {1'b0, pointer} + (ID_W + 1)'(k);
            end
        end
        if (sum >= (ID_W + 1)'(NUM_REQ)) begin
            sum = sum - (ID_W + 1)'(NUM_REQ);
        end
        pickId = sum[ID_W-1:0];
        pick   = found ? (NUM_REQ'(1) << pickId) : '0;
    end

endmodule

// File: rtl/scratch_mem_arbiter.sv
// Round-robin, hold-per-operation arbiter sharing one scratch RAM port pair and add/L_add units.
module scratch_mem_arbiter
    import scratch_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ID_W-1:0]           gnt_id,
    output logic                      busy,
    output logic                      err_timeout,
    output arb_state_t                dbgState,
    input  logic [NUM_REQ*ADDR_W-1:0] reqReadAddr,
    input  logic [NUM_REQ*ADDR_W-1:0] reqWriteAddr,
    input  logic [NUM_REQ-1:0]        reqWriteEn,
    input  logic [NUM_REQ*DATA_W-1:0] reqMemOut,
    input  logic [NUM_REQ*WORD_W-1:0] reqAddOutA,
    input  logic [NUM_REQ*WORD_W-1:0] reqAddOutB,
    input  logic [NUM_REQ*DATA_W-1:0] reqL_addOutA,
    input  logic [NUM_REQ*DATA_W-1:0] reqL_addOutB,
    output logic [ADDR_W-1:0]         memReadAddr,
    output logic [ADDR_W-1:0]         memWriteAddr,
    output logic                      memWriteEn,
    output logic [DATA_W-1:0]         memOut,
    output logic [WORD_W-1:0]         addOutA,
    output logic [WORD_W-1:0]         addOutB,
    output logic [DATA_W-1:0]         L_addOutA,
    output logic [DATA_W-1:0]         L_addOutB
);

    arb_state_t         state, nextState;
    logic [ID_W-1:0]    ptr, nextPtr, nextGntId;
    logic [NUM_REQ-1:0] nextGnt, pick;
    logic [ID_W-1:0]    pickId;
    logic               found, nextErr;
    logic [TIMER_W-1:0] timer, nextTimer;

    scratch_mem_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req     (req),
        .pointer (ptr),
        .pick    (pick),
        .pickId  (pickId),
        .found   (found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_id      <= '0;
            ptr         <= '0;
            timer       <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= nextState;
            gnt         <= nextGnt;
            gnt_id      <= nextGntId;
            ptr         <= nextPtr;
            timer       <= nextTimer;
            err_timeout <= nextErr;
        end
    end

    always_comb begin
        nextState = state;
        nextGnt   = gnt;
        nextGntId = gnt_id;
        nextPtr   = ptr;
        nextTimer = timer;
        nextErr   = err_timeout;
        case (state)
            IDLE, RELEASE: begin
                nextGnt   = '0;
                nextState = IDLE;
                if (found) begin
                    nextState = GRANT;
                    nextGnt   = pick;
                    nextGntId = pickId;
                    nextTimer = '0;
                end
            end
            GRANT: begin
                // Overlong grants are flagged but never revoked.
                if (timer == TIMER_W'(TIMEOUT)) begin
                    nextErr = 1'b1;
                end
                if (|(req & gnt)) begin
                    if (timer != '1) begin
                        nextTimer = timer + TIMER_W'(1);
                    end
                end else begin
                    nextState = RELEASE;
                    nextGnt   = '0;
                    nextPtr   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                end
            end
            default: begin
                nextState = IDLE;
                nextGnt   = '0;
            end
        endcase
    end

    assign busy     = |gnt;
    assign dbgState = state;

    // One-hot AND-OR mux: with no grant every shared output falls to zero.
    always_comb begin
        memReadAddr  = '0;
        memWriteAddr = '0;
        memWriteEn   = 1'b0;
        memOut       = '0;
        addOutA      = '0;
        addOutB      = '0;
        L_addOutA    = '0;
        L_addOutB    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                memReadAddr  |= reqReadAddr[i*ADDR_W +: ADDR_W];
                memWriteAddr |= reqWriteAddr[i*ADDR_W +: ADDR_W];
                memWriteEn   |= reqWriteEn[i];
                memOut       |= reqMemOut[i*DATA_W +: DATA_W];
                addOutA      |= reqAddOutA[i*WORD_W +: WORD_W];
                addOutB      |= reqAddOutB[i*WORD_W +: WORD_W];
                L_addOutA    |= reqL_addOutA[i*DATA_W +: DATA_W];
                L_addOutB    |= reqL_addOutB[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Directed plus randomized bench for scratch_mem_arbiter against a per-requester ownership model.
module tb_scratch_mem_arbiter;
    import scratch_mem_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]        req;
    logic [N-1:0]        gnt;
    logic [ID_W-1:0]     gnt_id;
    logic                busy, err_timeout;
    arb_state_t          dbgState;
    logic [N*ADDR_W-1:0] reqReadAddr, reqWriteAddr;
    logic [N-1:0]        wrEn;
    logic [N*DATA_W-1:0] reqMemOut, reqL_addOutA, reqL_addOutB;
    logic [N*WORD_W-1:0] reqAddOutA, reqAddOutB;
    logic [ADDR_W-1:0]   memReadAddr, memWriteAddr;
    logic                memWriteEn;
    logic [DATA_W-1:0]   memOut, L_addOutA, L_addOutB, memIn;
    logic [WORD_W-1:0]   addOutA, addOutB;

    logic [ADDR_W-1:0] rdA [N];
    logic [ADDR_W-1:0] wrA [N];
    logic [DATA_W-1:0] wD  [N];
    logic [DATA_W-1:0] lA  [N];
    logic [DATA_W-1:0] lB  [N];
    logic [WORD_W-1:0] aA  [N];
    logic [WORD_W-1:0] aB  [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            reqReadAddr[i*ADDR_W +: ADDR_W]  = rdA[i];
            reqWriteAddr[i*ADDR_W +: ADDR_W] = wrA[i];
            reqMemOut[i*DATA_W +: DATA_W]    = wD[i];
            reqL_addOutA[i*DATA_W +: DATA_W] = lA[i];
            reqL_addOutB[i*DATA_W +: DATA_W] = lB[i];
            reqAddOutA[i*WORD_W +: WORD_W]   = aA[i];
            reqAddOutB[i*WORD_W +: WORD_W]   = aB[i];
        end
    end

    scratch_mem_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
        .err_timeout(err_timeout), .dbgState(dbgState),
        .reqReadAddr(reqReadAddr), .reqWriteAddr(reqWriteAddr), .reqWriteEn(wrEn),
        .reqMemOut(reqMemOut), .reqAddOutA(reqAddOutA), .reqAddOutB(reqAddOutB),
        .reqL_addOutA(reqL_addOutA), .reqL_addOutB(reqL_addOutB),
        .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr), .memWriteEn(memWriteEn),
        .memOut(memOut), .addOutA(addOutA), .addOutB(addOutB),
        .L_addOutA(L_addOutA), .L_addOutB(L_addOutB)
    );

    // Scratch RAM: synchronous write, registered read.
    logic [DATA_W-1:0] ram [0:2047];
    always @(posedge clk) begin
        if (memWriteEn) ram[memWriteAddr] <= memOut;
        memIn <= ram[memReadAddr];
    end

    // Reference: who owns the resources, for how many cycles, and where the pointer sits.
    int mOwner = -1;
    int mPtr   = 0;
    int mAge   = 0;
    bit mGap   = 1'b0;
    bit mErr   = 1'b0;

    always @(posedge clk) begin : ref_model
        int o, p, a;
        bit g, e;
        o = mOwner; p = mPtr; a = mAge; g = mGap; e = mErr;
        if (reset) begin
            o = -1; p = 0; a = 0; g = 1'b0; e = 1'b0;
        end else if (o >= 0) begin
            if (a > TO) e = 1'b1;
            if (req[o]) a = a + 1;
            else begin
                p = (o + 1) % N; o = -1; g = 1'b1;
            end
        end else begin
            g = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (o < 0 && req[(p + k) % N]) begin
                    o = (p + k) % N; a = 1;
                end
            end
        end
        mOwner <= o; mPtr <= p; mAge <= a; mGap <= g; mErr <= e;
    end

    int passCnt  = 0;
    int totalCnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_model();
        logic [N-1:0] eg;
        arb_state_t   es;
        eg = '0;
        if (mOwner >= 0) eg[mOwner] = 1'b1;
        es = (mOwner >= 0) ? GRANT : (mGap ? RELEASE : IDLE);
        check("gnt", gnt, eg);
        check("busy", busy, mOwner >= 0);
        check("err_timeout", err_timeout, mErr);
        check("state", dbgState, es);
        if (mOwner >= 0) begin
            check("gnt_id", gnt_id, mOwner);
            check("memReadAddr", memReadAddr, rdA[mOwner]);
            check("memWriteAddr", memWriteAddr, wrA[mOwner]);
            check("memWriteEn", memWriteEn, wrEn[mOwner]);
            check("memOut", memOut, wD[mOwner]);
            check("addOutA", addOutA, aA[mOwner]);
            check("addOutB", addOutB, aB[mOwner]);
            check("L_addOutA", L_addOutA, lA[mOwner]);
            check("L_addOutB", L_addOutB, lB[mOwner]);
        end else begin
            check("idle_bus", {memReadAddr, memWriteAddr, memWriteEn, memOut}, 0);
            check("idle_ops", {addOutA, addOutB, L_addOutA}, 0);
            check("idle_lb", L_addOutB, 0);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req  = '0;
        wrEn = '0;
        for (int i = 0; i < N; i++) begin
            rdA[i] = '0; wrA[i] = '0; wD[i] = '0;
            lA[i] = '0; lB[i] = '0; aA[i] = '0; aB[i] = '0;
        end
    endtask

    int ids[$];
    int held [N];
    int zr;
    bit prevBusy;

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = '0;
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        step();
        step();
        check("rst_gnt", gnt, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_timeout, 0);

        // Single request, one-clock latency, write address routed from requester 1.
        reset  = 1'b0;
        wrA[1] = 11'd16;
        req    = 4'b0010;
        #1;
        check("t1_latency", gnt, 0);
        step();
        check("t1_gnt", gnt, 4'b0010);
        check("t1_gnt_id", gnt_id, 1);
        check("t1_wraddr", memWriteAddr, 11'd16);
        req = '0;
        step();
        step();

        // All four request together from pointer 0; each holds for 10 granted cycles.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b1111;
        ids.delete();
        for (int i = 0; i < N; i++) held[i] = 0;
        zr = 0;
        prevBusy = 1'b0;
        for (int c = 0; c < 80 && !(ids.size() == 4 && req == '0 && !busy); c++) begin
            step();
            if (busy && !prevBusy) begin
                if (ids.size() > 0) check("t2_gap", zr, 1);
                ids.push_back(int'(gnt_id));
                zr = 0;
            end
            if (!busy) zr++;
            prevBusy = busy;
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    held[i]++;
                    if (held[i] >= 10) req[i] = 1'b0;
                end
            end
        end
        check("t2_count", ids.size(), 4);
        for (int i = 0; i < ids.size() && i < 4; i++) check("t2_order", ids[i], i);

        // Requester 2 writes, requester 0 reads the same word back after the gap.
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        req = 4'b0100;
        step();
        wrA[2] = 11'd1024; wD[2] = 32'h1234_5678; wrEn[2] = 1'b1;
        step();
        req = 4'b0001; rdA[0] = 11'd1024;
        step();
        check("t3_gap_gnt", gnt, 0);
        check("t3_gap_we", memWriteEn, 0);
        wrEn[2] = 1'b0;
        step();
        check("t3_gnt0", gnt, 4'b0001);
        step();
        check("t3_readback", memIn, 32'h1234_5678);

        // A non-granted requester asserting its write enable must not reach the RAM.
        wrEn[1] = 1'b1; wrA[1] = 11'd500; wD[1] = 32'hDEAD_BEEF;
        step();
        check("t4_we", memWriteEn, 0);
        step();
        check("t4_ram", ram[500], 0);
        clear_inputs();
        step();
        step();

        // Timeout: requester 3 held 20 cycles against TIMEOUT=15.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b1000;
        for (int c = 1; c <= 20; c++) begin
            step();
            check("t5_hold", gnt, 4'b1000);
            check("t5_err", err_timeout, c >= TO + 2);
        end
        req = '0;
        step();
        step();
        check("t5_sticky", err_timeout, 1);

        // Move the pointer away from 0, then reset mid-grant.
        req = 4'b0100;
        step();
        req = '0;
        step();
        req = 4'b0100;
        step();
        step();
        reset = 1'b1;
        step();
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_err", err_timeout, 0);
        reset = 1'b0;
        req = 4'b1010;
        step();
        check("t6_first", gnt_id, 1);
        req = '0;
        step();
        step();

        // Randomized traffic: sticky-ish requests, fresh operands every cycle, rare resets.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3, 0) == 0) req[i] = ~req[i];
                rdA[i]  = ADDR_W'($urandom);
                wrA[i]  = ADDR_W'($urandom);
                wrEn[i] = 1'($urandom);
                wD[i]   = $urandom;
                lA[i]   = $urandom;
                lB[i]   = $urandom;
                aA[i]   = WORD_W'($urandom);
                aB[i]   = WORD_W'($urandom);
            end
            reset = ($urandom_range(99, 0) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
